if_fetch_controller: RTL and testbench
======================================

# if_fetch_controller

Instruction-fetch sequencer that drives the word address into the synchronous 256-word instruction memory and consumes the registered instruction word it returns one clock later. It owns the program counter, tracks the in-flight memory read, absorbs decode-stage stalls with a one-entry skid buffer, squashes on taken branches, and presents an aligned instruction/PC/valid triple to the decode stage.

## Interface
- MEM_DEPTH, 256: instruction memory depth in words; power of two; PC wraps modulo MEM_DEPTH.
- RESET_PC, 0: word address fetched first after reset; must be < MEM_DEPTH.
- Clk  in  1  single clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- Stall  in  1  decode cannot accept; hold ID outputs.
- Branch_Taken  in  1  redirect fetch this edge; overrides Stall.
- Branch_Target  in  32  redirect word address; only low log2(MEM_DEPTH) bits used.
- PC_IF  out  32  word address to instruction memory; registered; upper bits always 0.
- Instruction_IF  in  32  memory data; equals mem[PC_IF sampled at previous edge].
- Instruction_ID  out  32  instruction to decode; registered.
- PC_ID  out  32  word address of Instruction_ID; registered.
- Valid_ID  out  1  Instruction_ID/PC_ID hold a live instruction.

## Operation
- Internal state: PC_IF; req_valid/req_pc (address the memory sampled at the last edge, data now on Instruction_IF); skid_valid/skid_instr/skid_pc.
- Reset values: PC_IF=RESET_PC; req_valid=0; skid_valid=0; Instruction_ID=0; PC_ID=0; Valid_ID=0. Skid/req data regs reset to 0.
- Priority per edge: Reset > Branch_Taken > Stall > normal.
- Branch_Taken=1: PC_IF<=Branch_Target mod MEM_DEPTH; req_valid<=0; skid_valid<=0; Valid_ID<=0 (Instruction_ID/PC_ID may hold stale values).
- Stall=1 (no branch): Instruction_ID/PC_ID/Valid_ID hold; PC_IF holds; if req_valid and !skid_valid, skid <= {Instruction_IF, req_pc}, skid_valid<=1; req_valid<=0 (memory's re-read of PC_IF during stall is discarded).
- Normal: if skid_valid, ID <= {skid_instr, skid_pc, 1}, skid_valid<=0; else ID <= {Instruction_IF, req_pc, req_valid}. Then req_pc<=PC_IF, req_valid<=1, PC_IF<=(PC_IF+1) mod MEM_DEPTH.
- Invariant: req_valid and skid_valid never both 1; assertion required in bench.
- Wrap: PC_IF = MEM_DEPTH-1 advances to 0; PC_ID follows the fetched address, no carry into upper bits.
- No instruction is dropped or duplicated across any stall length; order on Valid_ID is strictly program order between branches.

## Timing
- Memory read latency: 1 cycle (address sampled at edge k, data valid after edge k).
- Fetch latency: PC_IF=A during cycle c -> Instruction_ID=mem[A], PC_ID=A, Valid_ID=1 after edge ending cycle c+1 (2 edges).
- After reset release: edge 1 samples RESET_PC; edge 2 Valid_ID=1 with PC_ID=RESET_PC; then one instruction per cycle.
- Stall release: first non-stall edge delivers skid entry; next edge delivers following address; no bubble when skid was filled.
- Stall with no live request (e.g. right after branch): release yields one bubble (Valid_ID=0) before the next instruction.
- Branch penalty: branch at edge e -> Valid_ID=0 after e and e+1; target instruction on ID after e+2.
- Branch_Taken and Stall same edge: branch wins; skid and request squashed.
- Reset asserted mid-stream: outputs return to reset values asynchronously, no edge needed; restart as after power-up.

## Test plan
- Reset release, mem[i]=0x1000_0000+i, RESET_PC=0, no stall -> Valid_ID rises after edge 2; PC_ID=0,1,2,... each cycle; Instruction_ID=0x1000_0000+PC_ID.
- Stall high 3 cycles while PC_ID=4 -> ID holds PC_ID=4 for 3 cycles; after release PC_ID=5,6,7 consecutive, no gap, no duplicate.
- Branch_Taken with Branch_Target=0x80 while PC_ID=10 -> two cycles Valid_ID=0, then PC_ID=0x80, 0x81; addresses 11/12 never appear valid.
- Branch_Taken and Stall simultaneously, Branch_Target=0x20 -> branch honoured; skid cleared; PC_ID=0x20 two edges later once Stall drops.
- RESET_PC=0xFE, run 4 cycles -> PC_ID sequence 0xFE, 0xFF, 0x00, 0x01; PC_IF upper 24 bits always 0.
- Reset asserted mid-stall with skid full -> PC_IF=RESET_PC, Valid_ID=0 immediately; skid contents never emitted after release.

Source files
------------

// File: rtl/if_fetch_controller.sv
// rtl/if_fetch_controller.sv - instruction-fetch sequencer with one-entry skid buffer
// Drives the PC into a 1-cycle synchronous memory and hands aligned instr/PC/valid to decode.
module if_fetch_controller #(
   parameter int MEM_DEPTH = 256,
   parameter int RESET_PC  = 0
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        Branch_Taken,
   input  logic [31:0] Branch_Target,
   output logic [31:0] PC_IF,
   input  logic [31:0] Instruction_IF,
   output logic [31:0] Instruction_ID,
   output logic [31:0] PC_ID,
   output logic        Valid_ID
);

   localparam int AW = $clog2(MEM_DEPTH);
   localparam logic [AW-1:0] RESET_PC_W = AW'(RESET_PC);

   logic [AW-1:0] pc_q, pc_d;
   logic          req_valid_q, req_valid_d;
   logic [AW-1:0] req_pc_q, req_pc_d;
   logic          skid_valid_q, skid_valid_d;
   logic [31:0]   skid_instr_q, skid_instr_d;
   logic [AW-1:0] skid_pc_q, skid_pc_d;
   logic [31:0]   id_instr_q, id_instr_d;
   logic [AW-1:0] id_pc_q, id_pc_d;
   logic          id_valid_q, id_valid_d;

   logic unused_target_bits;
   assign unused_target_bits = ^Branch_Target[31:AW];

   always_comb begin
      pc_d         = pc_q;
      req_valid_d  = req_valid_q;
      req_pc_d     = req_pc_q;
      skid_valid_d = skid_valid_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      id_instr_d   = id_instr_q;
      id_pc_d      = id_pc_q;
      id_valid_d   = id_valid_q;

      if (Branch_Taken) begin
         pc_d         = Branch_Target[AW-1:0];
         req_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
         id_valid_d   = 1'b0;
      end else if (Stall) begin
         // Capture the word arriving now; the memory's re-read of the held PC is discarded.
         if (req_valid_q && !skid_valid_q) begin
            skid_valid_d = 1'b1;
            skid_instr_d = Instruction_IF;
            skid_pc_d    = req_pc_q;
         end
         req_valid_d = 1'b0;
      end else begin
         if (skid_valid_q) begin
            id_instr_d   = skid_instr_q;
            id_pc_d      = skid_pc_q;
            id_valid_d   = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            id_instr_d = Instruction_IF;
            id_pc_d    = req_pc_q;
            id_valid_d = req_valid_q;
         end
         req_pc_d    = pc_q;
         req_valid_d = 1'b1;
         pc_d        = pc_q + AW'(1);
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pc_q         <= RESET_PC_W;
         req_valid_q  <= 1'b0;
         req_pc_q     <= '0;
         skid_valid_q <= 1'b0;
         skid_instr_q <= '0;
         skid_pc_q    <= '0;
         id_instr_q   <= '0;
         id_pc_q      <= '0;
         id_valid_q   <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         req_valid_q  <= req_valid_d;
         req_pc_q     <= req_pc_d;
         skid_valid_q <= skid_valid_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
         id_instr_q   <= id_instr_d;
         id_pc_q      <= id_pc_d;
         id_valid_q   <= id_valid_d;
      end
   end

   assign PC_IF          = {{(32-AW){1'b0}}, pc_q};
   assign PC_ID          = {{(32-AW){1'b0}}, id_pc_q};
   assign Instruction_ID = id_instr_q;
   assign Valid_ID       = id_valid_q;

endmodule

// File: tb/tb_if_fetch_controller.sv
// tb/tb_if_fetch_controller.sv - scoreboard bench for if_fetch_controller
// Main DUT at RESET_PC=0 exercises stalls/branches; second DUT at RESET_PC=0xFE checks wrap.
module tb_if_fetch_controller;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Stall = 1'b0;
   logic        Branch_Taken = 1'b0;
   logic [31:0] Branch_Target = '0;
   logic [31:0] PC_IF, Instruction_IF = '0, Instruction_ID, PC_ID;
   logic        Valid_ID;

   logic        tie_stall = 1'b0;
   logic        tie_branch = 1'b0;
   logic [31:0] tie_target = '0;
   logic [31:0] PC_IF2, Instruction_IF2 = '0, Instruction_ID2, PC_ID2;
   logic        Valid_ID2;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_pc;

   always #5 Clk = ~Clk;

   if_fetch_controller #(.MEM_DEPTH(256), .RESET_PC(0)) dut (
      .Clk(Clk), .Reset(Reset), .Stall(Stall), .Branch_Taken(Branch_Taken),
      .Branch_Target(Branch_Target), .PC_IF(PC_IF), .Instruction_IF(Instruction_IF),
      .Instruction_ID(Instruction_ID), .PC_ID(PC_ID), .Valid_ID(Valid_ID)
   );

   if_fetch_controller #(.MEM_DEPTH(256), .RESET_PC(32'hFE)) dut2 (
      .Clk(Clk), .Reset(Reset), .Stall(tie_stall), .Branch_Taken(tie_branch),
      .Branch_Target(tie_target), .PC_IF(PC_IF2), .Instruction_IF(Instruction_IF2),
      .Instruction_ID(Instruction_ID2), .PC_ID(PC_ID2), .Valid_ID(Valid_ID2)
   );

   // Synchronous memory: mem[i] = 0x1000_0000 + i
   always @(posedge Clk) begin
      Instruction_IF  <= 32'h1000_0000 + {24'd0, PC_IF[7:0]};
      Instruction_IF2 <= 32'h1000_0000 + {24'd0, PC_IF2[7:0]};
   end

   always @(negedge Clk) begin
      if (!Reset) begin
         checks++;
         assert (!(dut.req_valid_q && dut.skid_valid_q) && !(dut2.req_valid_q && dut2.skid_valid_q))
         else begin
            failures++;
            $display("FAIL invariant req_valid&skid_valid both set at %0t", $time);
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic run_until(input logic [31:0] pc);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!(Valid_ID && PC_ID == pc) && n < 300);
      checks++;
      if (!(Valid_ID && PC_ID == pc)) begin
         failures++;
         $display("FAIL run_until timeout: PC_ID=%h Valid_ID=%b want PC_ID=%h", PC_ID, Valid_ID, pc);
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      tick();
      checks++;
      if (PC_IF !== 32'h0 || PC_ID !== 32'h0 || Instruction_ID !== 32'h0 || Valid_ID !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: PC_IF=%h PC_ID=%h Instr=%h V=%b want 0/0/0/0", PC_IF, PC_ID, Instruction_ID, Valid_ID);
      end
      checks++;
      if (PC_IF2 !== 32'hFE || Valid_ID2 !== 1'b0) begin
         failures++;
         $display("FAIL reset_state_pc2: PC_IF=%h V=%b want 000000fe/0", PC_IF2, Valid_ID2);
      end
   endtask

   task automatic test_sequence();
      Reset = 1'b0;
      tick();
      checks++;
      if (Valid_ID !== 1'b0) begin
         failures++;
         $display("FAIL seq_edge1_valid: got %b want 0", Valid_ID);
      end
      for (int i = 0; i < 4; i++) exp_q.push_back(i);
      while (exp_q.size() > 0) begin
         tick();
         exp_pc = exp_q.pop_front();
         checks++;
         if (Valid_ID !== 1'b1 || PC_ID !== exp_pc || Instruction_ID !== 32'h1000_0000 + exp_pc
             || PC_IF[31:8] !== 24'd0) begin
            failures++;
            $display("FAIL seq: V=%b PC_ID=%h Instr=%h PC_IF=%h want V=1 PC_ID=%h", Valid_ID, PC_ID, Instruction_ID, PC_IF, exp_pc);
         end
      end
   endtask

   task automatic test_stall();
      run_until(32'd4);
      Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (Valid_ID !== 1'b1 || PC_ID !== 32'd4 || Instruction_ID !== 32'h1000_0004) begin
            failures++;
            $display("FAIL stall_hold[%0d]: V=%b PC_ID=%h Instr=%h want 1/4/10000004", i, Valid_ID, PC_ID, Instruction_ID);
         end
      end
      Stall = 1'b0;
      for (int i = 5; i < 8; i++) exp_q.push_back(i);
      while (exp_q.size() > 0) begin
         tick();
         exp_pc = exp_q.pop_front();
         checks++;
         if (Valid_ID !== 1'b1 || PC_ID !== exp_pc || Instruction_ID !== 32'h1000_0000 + exp_pc) begin
            failures++;
            $display("FAIL stall_release: V=%b PC_ID=%h Instr=%h want V=1 PC_ID=%h", Valid_ID, PC_ID, Instruction_ID, exp_pc);
         end
      end
   endtask

   task automatic test_branch();
      run_until(32'd10);
      Branch_Taken  = 1'b1;
      Branch_Target = 32'h80;
      tick();
      Branch_Taken = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (Valid_ID !== 1'b0) begin
            failures++;
            $display("FAIL branch_bubble[%0d]: V=%b PC_ID=%h want V=0", i, Valid_ID, PC_ID);
         end
         if (i == 0) tick();
      end
      exp_q.push_back(32'h80);
      exp_q.push_back(32'h81);
      while (exp_q.size() > 0) begin
         tick();
         exp_pc = exp_q.pop_front();
         checks++;
         if (Valid_ID !== 1'b1 || PC_ID !== exp_pc || Instruction_ID !== 32'h1000_0000 + exp_pc) begin
            failures++;
            $display("FAIL branch_target: V=%b PC_ID=%h Instr=%h want V=1 PC_ID=%h", Valid_ID, PC_ID, Instruction_ID, exp_pc);
         end
      end
   endtask

   task automatic test_branch_stall();
      Stall = 1'b1;
      tick();
      checks++;
      if (dut.skid_valid_q !== 1'b1) begin
         failures++;
         $display("FAIL bs_skid_fill: skid_valid=%b want 1", dut.skid_valid_q);
      end
      Branch_Taken  = 1'b1;
      Branch_Target = 32'h0000_0120;
      tick();
      Branch_Taken = 1'b0;
      Stall        = 1'b0;
      checks++;
      if (Valid_ID !== 1'b0 || PC_IF !== 32'h20) begin
         failures++;
         $display("FAIL bs_edge_e: V=%b PC_IF=%h want 0/00000020", Valid_ID, PC_IF);
      end
      tick();
      checks++;
      if (Valid_ID !== 1'b0) begin
         failures++;
         $display("FAIL bs_edge_e1: V=%b PC_ID=%h want V=0", Valid_ID, PC_ID);
      end
      exp_q.push_back(32'h20);
      exp_q.push_back(32'h21);
      while (exp_q.size() > 0) begin
         tick();
         exp_pc = exp_q.pop_front();
         checks++;
         if (Valid_ID !== 1'b1 || PC_ID !== exp_pc || Instruction_ID !== 32'h1000_0000 + exp_pc) begin
            failures++;
            $display("FAIL bs_target: V=%b PC_ID=%h Instr=%h want V=1 PC_ID=%h", Valid_ID, PC_ID, Instruction_ID, exp_pc);
         end
      end
   endtask

   task automatic test_stall_after_branch();
      Branch_Taken  = 1'b1;
      Branch_Target = 32'h40;
      tick();
      Branch_Taken = 1'b0;
      Stall        = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 1) Stall = 1'b0;
         checks++;
         if (Valid_ID !== 1'b0) begin
            failures++;
            $display("FAIL sab_bubble[%0d]: V=%b PC_ID=%h want V=0", i, Valid_ID, PC_ID);
         end
      end
      exp_q.push_back(32'h40);
      exp_q.push_back(32'h41);
      while (exp_q.size() > 0) begin
         tick();
         exp_pc = exp_q.pop_front();
         checks++;
         if (Valid_ID !== 1'b1 || PC_ID !== exp_pc) begin
            failures++;
            $display("FAIL sab_target: V=%b PC_ID=%h want V=1 PC_ID=%h", Valid_ID, PC_ID, exp_pc);
         end
      end
   endtask

   task automatic test_reset_mid_stall();
      Stall = 1'b1;
      tick();
      tick();
      #2;
      Reset = 1'b1;
      #1;
      checks++;
      if (PC_IF !== 32'h0 || Valid_ID !== 1'b0 || PC_ID !== 32'h0 || Instruction_ID !== 32'h0) begin
         failures++;
         $display("FAIL async_reset: PC_IF=%h V=%b PC_ID=%h Instr=%h want all 0", PC_IF, Valid_ID, PC_ID, Instruction_ID);
      end
      tick();
      Reset = 1'b0;
      Stall = 1'b0;
      tick();
      checks++;
      if (Valid_ID !== 1'b0) begin
         failures++;
         $display("FAIL rms_edge1: V=%b PC_ID=%h want V=0", Valid_ID, PC_ID);
      end
      for (int i = 0; i < 3; i++) exp_q.push_back(i);
      while (exp_q.size() > 0) begin
         tick();
         exp_pc = exp_q.pop_front();
         checks++;
         if (Valid_ID !== 1'b1 || PC_ID !== exp_pc || Instruction_ID !== 32'h1000_0000 + exp_pc) begin
            failures++;
            $display("FAIL rms_restart: V=%b PC_ID=%h Instr=%h want V=1 PC_ID=%h", Valid_ID, PC_ID, Instruction_ID, exp_pc);
         end
      end
   endtask

   task automatic test_wrap();
      Reset = 1'b1;
      #1;
      checks++;
      if (PC_IF2 !== 32'hFE) begin
         failures++;
         $display("FAIL wrap_reset_pc: PC_IF=%h want 000000fe", PC_IF2);
      end
      tick();
      Reset = 1'b0;
      tick();
      checks++;
      if (Valid_ID2 !== 1'b0) begin
         failures++;
         $display("FAIL wrap_edge1: V=%b want 0", Valid_ID2);
      end
      exp_q.push_back(32'hFE);
      exp_q.push_back(32'hFF);
      exp_q.push_back(32'h00);
      exp_q.push_back(32'h01);
      while (exp_q.size() > 0) begin
         tick();
         exp_pc = exp_q.pop_front();
         checks++;
         if (Valid_ID2 !== 1'b1 || PC_ID2 !== exp_pc || Instruction_ID2 !== 32'h1000_0000 + exp_pc
             || PC_IF2[31:8] !== 24'd0) begin
            failures++;
            $display("FAIL wrap: V=%b PC_ID=%h Instr=%h PC_IF=%h want V=1 PC_ID=%h", Valid_ID2, PC_ID2, Instruction_ID2, PC_IF2, exp_pc);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_stall();
      test_branch();
      test_branch_stall();
      test_stall_after_branch();
      test_reset_mid_stall();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
